branch_resolve_ctrl: RTL and testbench

Decode-stage sequencer around the branch/trap comparator. It decides when a branch or conditional trap in D may resolve, stalling while forwarded comparator operands are not ready. It drives the PC redirect and branch-likely delay-slot annulment, tags the delay-slot instruction for CP0 BD, and holds a trap request until CP0 accepts it. It sits between the hazard unit, the comparator outputs, the fetch PC mux and CP0.

---
 rtl/branch_resolve_ctrl.sv | 109 ++++++++++
 tb/tb_branch_resolve_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - decode-stage branch/trap resolve sequencer
// Stalls D until comparator operands are final, drives redirect/annul, tags delay slots, holds traps for CP0.
module branch_resolve_ctrl #(
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            validD,
   input  logic            stallD,
   input  logic            flush,
   input  logic            is_branch,
   input  logic            is_likely,
   input  logic            is_trap,
   input  logic            opnd_ready,
   input  logic            cmp_y,
   input  logic            cmp_trap,
   input  logic [PC_W-1:0] pcD,
   input  logic [PC_W-1:0] br_target,
   output logic            stall_req,
   output logic            pc_redirect,
   output logic [PC_W-1:0] pc_target,
   output logic            annul_slot,
   output logic            in_slot,
   output logic            trap_req,
   output logic [PC_W-1:0] trap_epc,
   output logic            trap_bd,
   input  logic            trap_ack
);

   typedef enum logic [1:0] {IDLE, WAIT, SLOT, TRAP} state_t;

   state_t          state, state_n;
   logic            slot_q;
   logic            slot_n;
   logic            decision;
   logic            resolve;
   logic            br_res;
   logic            tr_res;
   logic            annul;
   logic            trap_fire;
   logic [PC_W-1:0] epc_n;

   // slot_q marks the D instruction as a delay slot; it survives a SLOT->WAIT detour
   assign decision  = validD & ((is_branch & ~slot_q) | is_trap);
   assign resolve   = (state != TRAP) & decision & opnd_ready & ~stallD & ~flush;
   assign br_res    = resolve & is_branch & ~slot_q;
   assign tr_res    = resolve & ~br_res & is_trap;
   assign annul     = br_res & is_likely & ~cmp_y;
   assign trap_fire = tr_res & cmp_trap;
   assign epc_n     = slot_q ? pcD - PC_W'(4) : pcD;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= IDLE;
         slot_q <= 1'b0;
      end else begin
         state  <= state_n;
         slot_q <= slot_n;
      end
   end

   always_comb begin
      state_n = state;
      if (flush) begin
         state_n = IDLE;
      end else if (state == TRAP) begin
         if (trap_ack) state_n = IDLE;
      end else if (decision & ~opnd_ready) begin
         state_n = WAIT;
      end else if (br_res) begin
         state_n = annul ? IDLE : SLOT;
      end else if (tr_res) begin
         state_n = cmp_trap ? TRAP : IDLE;
      end else if (state == SLOT) begin
         if (validD & ~stallD & ~decision) state_n = IDLE;
      end else if (state == WAIT) begin
         if (~decision) state_n = IDLE;
      end
      slot_n = (state_n == SLOT) | ((state_n == WAIT) & slot_q);
   end

   always_comb begin
      stall_req   = 1'b0;
      pc_redirect = 1'b0;
      pc_target   = '0;
      annul_slot  = 1'b0;
      if (resetn & ~flush) begin
         stall_req   = (state == TRAP) | ((state != TRAP) & decision & ~opnd_ready);
         pc_redirect = br_res & cmp_y;
         pc_target   = br_res ? br_target : '0;
         annul_slot  = annul;
      end
      in_slot  = slot_q;
      trap_req = (state == TRAP);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         trap_epc <= '0;
         trap_bd  <= 1'b0;
      end else if (trap_fire) begin
         trap_epc <= epc_n;
         trap_bd  <= slot_q;
      end else if (state_n != TRAP) begin
         trap_bd  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        validD, stallD, flush, is_branch, is_likely, is_trap;
   logic        opnd_ready, cmp_y, cmp_trap, trap_ack;
   logic [31:0] pcD, br_target;
   logic        stall_req, pc_redirect, annul_slot, in_slot, trap_req, trap_bd;
   logic [31:0] pc_target, trap_epc;
   int          checks = 0;
   int          failures = 0;

   branch_resolve_ctrl #(.PC_W(32)) dut (
      .clk(clk), .resetn(resetn), .validD(validD), .stallD(stallD), .flush(flush),
      .is_branch(is_branch), .is_likely(is_likely), .is_trap(is_trap),
      .opnd_ready(opnd_ready), .cmp_y(cmp_y), .cmp_trap(cmp_trap),
      .pcD(pcD), .br_target(br_target), .stall_req(stall_req),
      .pc_redirect(pc_redirect), .pc_target(pc_target), .annul_slot(annul_slot),
      .in_slot(in_slot), .trap_req(trap_req), .trap_epc(trap_epc),
      .trap_bd(trap_bd), .trap_ack(trap_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one edge; inputs change 1 time unit after it, checks follow another unit later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      validD = 0; stallD = 0; flush = 0; is_branch = 0; is_likely = 0; is_trap = 0;
      opnd_ready = 1; cmp_y = 0; cmp_trap = 0; trap_ack = 0; pcD = 0; br_target = 0;
   endtask

   task automatic instr(input logic br, input logic lk, input logic tp, input logic [31:0] pc);
      clr();
      validD = 1; is_branch = br; is_likely = lk; is_trap = tp; pcD = pc;
   endtask

   initial begin
      clr();
      resetn = 0;
      #1;
      chk("rst_stall", stall_req, 0);
      chk("rst_redir", pc_redirect, 0);
      chk("rst_target", pc_target, 0);
      chk("rst_trapreq", trap_req, 0);
      chk("rst_epc", trap_epc, 0);
      chk("rst_inslot", in_slot, 0);
      step(); step();
      resetn = 1;
      step();

      // taken BEQ, then a branch sitting in its delay slot is ignored
      instr(1, 0, 0, 32'h100); cmp_y = 1; br_target = 32'h200; #1;
      chk("beq_redir", pc_redirect, 1);
      chk("beq_target", pc_target, 32'h200);
      chk("beq_stall", stall_req, 0);
      step();
      instr(1, 0, 0, 32'h104); cmp_y = 1; br_target = 32'h500; #1;
      chk("beq_slot_in", in_slot, 1);
      chk("beq_slot_br_ignored", pc_redirect, 0);
      step();
      instr(0, 0, 0, 32'h200); #1;
      chk("beq_after_slot", in_slot, 0);
      step();

      // BNEL not taken annuls the slot
      instr(1, 1, 0, 32'h120); cmp_y = 0; #1;
      chk("bnel_annul", annul_slot, 1);
      chk("bnel_redir", pc_redirect, 0);
      step();
      instr(0, 0, 0, 32'h124); #1;
      chk("bnel_inslot", in_slot, 0);
      chk("bnel_annul_1cyc", annul_slot, 0);
      step();

      // BGTZ waits two cycles for operands
      instr(1, 0, 0, 32'h140); opnd_ready = 0; br_target = 32'h180; cmp_y = 1; #1;
      chk("bgtz_stall1", stall_req, 1);
      step(); #1;
      chk("bgtz_stall2", stall_req, 1);
      chk("bgtz_noredir", pc_redirect, 0);
      step();
      opnd_ready = 1; #1;
      chk("bgtz_stall3", stall_req, 0);
      chk("bgtz_redir", pc_redirect, 1);
      chk("bgtz_target", pc_target, 32'h180);
      step();
      clr(); #1;
      chk("bgtz_slot_empty", in_slot, 1);
      step();
      instr(0, 0, 0, 32'h144); #1;
      chk("bgtz_slot", in_slot, 1);
      step();
      clr(); #1;
      chk("bgtz_idle", in_slot, 0);

      // TEQ fires outside a slot, acked after two cycles
      instr(0, 0, 1, 32'h300); cmp_trap = 1; #1;
      chk("teq_no_req_yet", trap_req, 0);
      step();
      clr(); #1;
      chk("teq_req", trap_req, 1);
      chk("teq_epc", trap_epc, 32'h300);
      chk("teq_bd", trap_bd, 0);
      chk("teq_stall", stall_req, 1);
      step(); #1;
      chk("teq_hold", trap_req, 1);
      trap_ack = 1;
      step();
      trap_ack = 0; #1;
      chk("teq_acked", trap_req, 0);
      chk("teq_stall_off", stall_req, 0);

      // trap in the slot of a branch at 0x400, acked on its first cycle
      instr(1, 0, 0, 32'h400); cmp_y = 1; br_target = 32'h800;
      step();
      instr(0, 0, 1, 32'h404); cmp_trap = 1; #1;
      chk("slot_trap_inslot", in_slot, 1);
      step();
      clr(); #1;
      chk("slot_trap_req", trap_req, 1);
      chk("slot_trap_epc", trap_epc, 32'h400);
      chk("slot_trap_bd", trap_bd, 1);
      trap_ack = 1;
      step();
      trap_ack = 0; #1;
      chk("slot_trap_done", trap_req, 0);
      chk("slot_trap_bd_clr", trap_bd, 0);

      // delay-slot trap at PC 0 wraps the EPC
      instr(1, 0, 0, 32'hFFFF_FFFC); cmp_y = 1;
      step();
      instr(0, 0, 1, 32'h0); cmp_trap = 1;
      step();
      clr(); #1;
      chk("wrap_epc", trap_epc, 32'hFFFF_FFFC);
      // flush in TRAP beats a simultaneous ack
      flush = 1; trap_ack = 1; #1;
      chk("flush_trap_stall", stall_req, 0);
      step();
      clr(); #1;
      chk("flush_trap_req", trap_req, 0);
      chk("flush_trap_bd", trap_bd, 0);
      chk("flush_trap_stall2", stall_req, 0);

      // flush while waiting on operands
      instr(1, 0, 0, 32'h500); opnd_ready = 0;
      step(); #1;
      chk("wait_stall", stall_req, 1);
      flush = 1; #1;
      chk("flush_wait_stall", stall_req, 0);
      step();
      clr(); #1;
      chk("flush_wait_after", stall_req, 0);
      chk("flush_wait_inslot", in_slot, 0);

      // stallD holds off resolution
      instr(1, 0, 0, 32'h600); cmp_y = 1; br_target = 32'h700; stallD = 1; #1;
      chk("stallD_redir", pc_redirect, 0);
      chk("stallD_stall", stall_req, 0);
      step(); #1;
      chk("stallD_no_slot", in_slot, 0);
      stallD = 0; #1;
      chk("stallD_release_redir", pc_redirect, 1);
      step();
      instr(0, 0, 0, 32'h604); #1;
      chk("stallD_slot", in_slot, 1);
      step();

      // reset asserted mid-WAIT, with a pending trap-free wait
      instr(1, 0, 0, 32'h900); opnd_ready = 0;
      step(); #1;
      chk("rstwait_stall", stall_req, 1);
      resetn = 0; #1;
      chk("rstwait_stall0", stall_req, 0);
      chk("rstwait_trap", trap_req, 0);
      chk("rstwait_inslot", in_slot, 0);
      clr();
      step();
      resetn = 1;
      step(); #1;
      chk("rstwait_idle", stall_req, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
